// File: rtl/imm_gen_pkg.sv
// Shared immediate-format tags, opcode constants and small decode helpers for imm_gen_stage.
package imm_gen_pkg;

  typedef enum logic [2:0] {
    IMM_NONE  = 3'd0,
    IMM_I     = 3'd1,
    IMM_S     = 3'd2,
    IMM_B     = 3'd3,
    IMM_U     = 3'd4,
    IMM_J     = 3'd5,
    IMM_SHAMT = 3'd6,
    IMM_Z     = 3'd7
  } imm_type_t;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  // SLLI/SRLI/SRAI carry a shift amount instead of a signed immediate
  function automatic logic is_shift(input logic [2:0] funct3);
    return (funct3 == 3'b001) || (funct3 == 3'b101);
  endfunction

endpackage

// File: rtl/imm_decode.sv
// Combinational RISC-V immediate decoder: instruction word in, XLEN immediate and format tag out.
// Define IMMGEN_CSR_EN to decode SYSTEM/CSR immediates; otherwise SYSTEM yields NONE.
module imm_decode
  import imm_gen_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instruction,
  output logic [XLEN-1:0] imm,
  output imm_type_t       imm_type
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [31:0] i_imm;
  logic [31:0] s_imm;
  logic [31:0] b_imm;
  logic [31:0] u_imm;
  logic [31:0] j_imm;
  logic [5:0]  shamt;

  assign opcode = instruction[6:0];
  assign funct3 = instruction[14:12];

  assign i_imm = {{20{instruction[31]}}, instruction[31:20]};
  assign s_imm = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
  assign b_imm = {{19{instruction[31]}}, instruction[31], instruction[7],
                  instruction[30:25], instruction[11:8], 1'b0};
  assign u_imm = {instruction[31:12], 12'b0};
  assign j_imm = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                  instruction[20], instruction[30:21], 1'b0};

  // RV64 shifts use a 6-bit amount; RV32 ignores bit 25
  assign shamt = (XLEN == 64) ? instruction[25:20] : {1'b0, instruction[24:20]};

  function automatic logic [XLEN-1:0] sext(input logic [31:0] v);
    logic [XLEN-1:0] r;
    r       = {XLEN{v[31]}};
    r[31:0] = v;
    return r;
  endfunction

  always_comb begin
    imm      = '0;
    imm_type = IMM_NONE;
    case (opcode)
      OP_IMM: begin
        if (is_shift(funct3)) begin
          imm      = XLEN'(shamt);
          imm_type = IMM_SHAMT;
        end else begin
          imm      = sext(i_imm);
          imm_type = IMM_I;
        end
      end
      OP_LOAD, OP_JALR: begin
        imm      = sext(i_imm);
        imm_type = IMM_I;
      end
      OP_STORE: begin
        imm      = sext(s_imm);
        imm_type = IMM_S;
      end
      OP_BRANCH: begin
        imm      = sext(b_imm);
        imm_type = IMM_B;
      end
      OP_LUI, OP_AUIPC: begin
        imm      = sext(u_imm);
        imm_type = IMM_U;
      end
      OP_JAL: begin
        imm      = sext(j_imm);
        imm_type = IMM_J;
      end
`ifdef IMMGEN_CSR_EN
      OP_SYSTEM: begin
        if (funct3[2]) begin
          imm      = XLEN'(instruction[19:15]);
          imm_type = IMM_Z;
        end else if (funct3 != 3'b000) begin
          imm      = sext(i_imm);
          imm_type = IMM_I;
        end
      end
`endif
      default: begin
        imm      = '0;
        imm_type = IMM_NONE;
      end
    endcase
  end

endmodule

// File: rtl/imm_gen_stage.sv
// Pipeline stage that decodes immediates on entry and buffers results in a DEPTH-entry FIFO.
// Optional macro IMMGEN_CSR_EN enables CSR immediate decode in imm_decode.
module imm_gen_stage
  import imm_gen_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instruction,
  input  logic [XLEN-1:0] pc_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] imm_out,
  output imm_type_t       imm_type,
  output logic [31:0]     instr_out,
  output logic [XLEN-1:0] pc_out
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [XLEN-1:0] imm_q   [DEPTH];
  imm_type_t       type_q  [DEPTH];
  logic [31:0]     instr_q [DEPTH];
  logic [XLEN-1:0] pc_q    [DEPTH];

  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic [XLEN-1:0] dec_imm;
  imm_type_t       dec_type;
  logic            push;
  logic            pop;

  imm_decode #(.XLEN(XLEN)) u_decode (
    .instruction (instruction),
    .imm         (dec_imm),
    .imm_type    (dec_type)
  );

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign in_ready  = (count < FULL_CNT);
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;

  // Payload storage needs no reset: reads are gated by count
  always_ff @(posedge clk) begin
    if (push) begin
      imm_q[wr_ptr]   <= dec_imm;
      type_q[wr_ptr]  <= dec_type;
      instr_q[wr_ptr] <= instruction;
      pc_q[wr_ptr]    <= pc_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Head outputs read as zero whenever the buffer is empty
  always_comb begin
    imm_out   = '0;
    imm_type  = IMM_NONE;
    instr_out = '0;
    pc_out    = '0;
    if (out_valid) begin
      imm_out   = imm_q[rd_ptr];
      imm_type  = type_q[rd_ptr];
      instr_out = instr_q[rd_ptr];
      pc_out    = pc_q[rd_ptr];
    end
  end

endmodule

// File: tb/tb_imm_gen_stage.sv
// Directed self-checking bench for imm_gen_stage (XLEN=32, DEPTH=2); honours IMMGEN_CSR_EN.
module tb_imm_gen_stage;
  import imm_gen_pkg::*;

  localparam int XLEN  = 32;
  localparam int DEPTH = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     instruction;
  logic [XLEN-1:0] pc_in;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] imm_out;
  imm_type_t       imm_type;
  logic [31:0]     instr_out;
  logic [XLEN-1:0] pc_out;

  int checks = 0;
  int passed = 0;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] imm;
    imm_type_t   t;
  } vec_t;

  always #5 clk = ~clk;

  imm_gen_stage #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .instruction (instruction),
    .pc_in       (pc_in),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .imm_out     (imm_out),
    .imm_type    (imm_type),
    .instr_out   (instr_out),
    .pc_out      (pc_out)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; instruction = 32'hFFF00093; pc_in = 32'h40; out_ready = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b0) $display("[TB] FAIL reset_valid: got %b expected 0", out_valid); else passed++;
    checks++; if (in_ready !== 1'b1) $display("[TB] FAIL reset_ready: got %b expected 1", in_ready); else passed++;
    checks++; if (imm_out !== 32'h0) $display("[TB] FAIL reset_imm: got %h expected 0", imm_out); else passed++;
    checks++; if (imm_type !== IMM_NONE) $display("[TB] FAIL reset_type: got %0d expected %0d", imm_type, IMM_NONE); else passed++;
    checks++; if (instr_out !== 32'h0 || pc_out !== 32'h0) $display("[TB] FAIL reset_data: got %h/%h expected 0/0", instr_out, pc_out); else passed++;
    rst = 1'b0; in_valid = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b0) $display("[TB] FAIL reset_drop: got %b expected 0", out_valid); else passed++;
  endtask

  task automatic test_decode();
    vec_t vecs[$];
    vecs.push_back('{32'hFFF00093, 32'hFFFFFFFF, IMM_I});     // addi x1,x0,-1
    vecs.push_back('{32'hFE112E23, 32'hFFFFFFFC, IMM_S});     // sw
    vecs.push_back('{32'hFE000CE3, 32'hFFFFFFF8, IMM_B});     // beq -8
    vecs.push_back('{32'h123450B7, 32'h12345000, IMM_U});     // lui
    vecs.push_back('{32'h80000017, 32'h80000000, IMM_U});     // auipc
    vecs.push_back('{32'hFFFFF0EF, 32'hFFFFFFFE, IMM_J});     // jal -2
    vecs.push_back('{32'h0080A103, 32'h00000008, IMM_I});     // lw 8
    vecs.push_back('{32'h00509093, 32'h00000005, IMM_SHAMT}); // slli 5
    vecs.push_back('{32'h4030D093, 32'h00000003, IMM_SHAMT}); // srai 3
    vecs.push_back('{32'h0000000B, 32'h00000000, IMM_NONE});  // custom opcode
    vecs.push_back('{32'h00000073, 32'h00000000, IMM_NONE});  // ecall
`ifdef IMMGEN_CSR_EN
    vecs.push_back('{32'h34011073, 32'h00000340, IMM_I});
    vecs.push_back('{32'h3402D073, 32'h00000005, IMM_Z});
`else
    vecs.push_back('{32'h34011073, 32'h00000000, IMM_NONE});
    vecs.push_back('{32'h3402D073, 32'h00000000, IMM_NONE});
`endif
    out_ready = 1'b1;
    foreach (vecs[i]) begin
      instruction = vecs[i].instr; pc_in = 32'h1000 + 32'(i * 4); in_valid = 1'b1;
      tick();
      checks++; if (out_valid !== 1'b1) $display("[TB] FAIL dec%0d_valid: got %b expected 1", i, out_valid); else passed++;
      checks++; if (imm_out !== vecs[i].imm) $display("[TB] FAIL dec%0d_imm: got %h expected %h", i, imm_out, vecs[i].imm); else passed++;
      checks++; if (imm_type !== vecs[i].t) $display("[TB] FAIL dec%0d_type: got %0d expected %0d", i, imm_type, vecs[i].t); else passed++;
      checks++; if (instr_out !== vecs[i].instr || pc_out !== 32'h1000 + 32'(i * 4))
        $display("[TB] FAIL dec%0d_data: got %h/%h expected %h/%h", i, instr_out, pc_out, vecs[i].instr, 32'h1000 + 32'(i * 4)); else passed++;
      in_valid = 1'b0;
      tick();
      checks++; if (out_valid !== 1'b0 || imm_out !== 32'h0) $display("[TB] FAIL dec%0d_empty: got %b/%h expected 0/0", i, out_valid, imm_out); else passed++;
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0; in_valid = 1'b1;
    instruction = 32'h00100093; pc_in = 32'h200;
    tick();
    checks++; if (in_ready !== 1'b1) $display("[TB] FAIL bp_ready1: got %b expected 1", in_ready); else passed++;
    instruction = 32'h00200093; pc_in = 32'h204;
    tick();
    checks++; if (in_ready !== 1'b0) $display("[TB] FAIL bp_ready2: got %b expected 0", in_ready); else passed++;
    instruction = 32'h00300093; pc_in = 32'h208;
    tick();
    checks++; if (in_ready !== 1'b0 || instr_out !== 32'h00100093)
      $display("[TB] FAIL bp_full: got %b/%h expected 0/00100093", in_ready, instr_out); else passed++;
    out_ready = 1'b1;
    tick();
    checks++; if (instr_out !== 32'h00200093 || imm_out !== 32'h2 || in_ready !== 1'b1)
      $display("[TB] FAIL bp_second: got %h/%h/%b expected 00200093/2/1", instr_out, imm_out, in_ready); else passed++;
    tick();
    checks++; if (instr_out !== 32'h00300093 || pc_out !== 32'h208)
      $display("[TB] FAIL bp_third: got %h/%h expected 00300093/208", instr_out, pc_out); else passed++;
    in_valid = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b0) $display("[TB] FAIL bp_drain: got %b expected 0", out_valid); else passed++;
  endtask

  task automatic test_flush();
    out_ready = 1'b0; in_valid = 1'b1;
    instruction = 32'h00A00093; pc_in = 32'h300;
    tick();
    instruction = 32'h00B00093; pc_in = 32'h304;
    tick();
    flush = 1'b1; out_ready = 1'b1; instruction = 32'h00D00093; pc_in = 32'h308;
    tick();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || instr_out !== 32'h0)
      $display("[TB] FAIL flush_clear: got %b/%b/%h expected 0/1/0", out_valid, in_ready, instr_out); else passed++;
    flush = 1'b0; in_valid = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b0) $display("[TB] FAIL flush_drop: got %b expected 0", out_valid); else passed++;
    out_ready = 1'b0; in_valid = 1'b1; instruction = 32'h00E00093; pc_in = 32'h30C;
    tick();
    checks++; if (instr_out !== 32'h00E00093 || imm_out !== 32'hE)
      $display("[TB] FAIL flush_after: got %h/%h expected 00E00093/e", instr_out, imm_out); else passed++;
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
  endtask

  task automatic test_wrap();
    logic [31:0] w;
    out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      w = {20'(i + 1), 12'h0B7};
      instruction = w; pc_in = 32'h500 + 32'(i * 4);
      tick();
      checks++; if (instr_out !== w || imm_out !== {20'(i + 1), 12'h000} || imm_type !== IMM_U)
        $display("[TB] FAIL wrap%0d: got %h/%h expected %h/%h", i, instr_out, imm_out, w, {20'(i + 1), 12'h000}); else passed++;
    end
    in_valid = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b0) $display("[TB] FAIL wrap_drain: got %b expected 0", out_valid); else passed++;
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0; in_valid = 1'b1;
    instruction = 32'hFE112E23; pc_in = 32'h600;
    tick();
    instruction = 32'hFE000CE3; pc_in = 32'h604;
    tick();
    rst = 1'b1; out_ready = 1'b1; instruction = 32'h123450B7;
    tick();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("[TB] FAIL rstmid_ctrl: got %b/%b expected 0/1", out_valid, in_ready); else passed++;
    checks++; if (imm_out !== 32'h0 || instr_out !== 32'h0 || pc_out !== 32'h0 || imm_type !== IMM_NONE)
      $display("[TB] FAIL rstmid_data: got %h/%h/%h expected 0/0/0", imm_out, instr_out, pc_out); else passed++;
    rst = 1'b0; in_valid = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b0) $display("[TB] FAIL rstmid_after: got %b expected 0", out_valid); else passed++;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    instruction = '0; pc_in = '0;
    tick();
    test_reset();
    test_decode();
    test_back_to_back();
    test_flush();
    test_wrap();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/imm_gen_stage.md
IMM_GEN_STAGE -- requirements
Module: imm_gen_stage

Interface
REQ-001 Parameter XLEN, default 32, datapath width of immediate and PC (legal values 32, 64).
REQ-002 Parameter DEPTH, default 2, output buffer entries (legal values 1..4).
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 flush  in  1  discard all buffered and incoming entries this cycle.
REQ-006 in_valid  in  1  upstream offers instruction.
REQ-007 in_ready  out  1  stage can accept; high when buffer not full.
REQ-008 instruction  in  32  raw instruction word.
REQ-009 pc_in  in  XLEN  PC of offered instruction.
REQ-010 out_valid  out  1  head entry valid.
REQ-011 out_ready  in  1  downstream consumes head.
REQ-012 imm_out  out  XLEN  decoded immediate of head entry.
REQ-013 imm_type  out  3  format tag of head entry (imm_type_t).
REQ-014 instr_out  out  32  instruction word of head entry.
REQ-015 pc_out  out  XLEN  PC of head entry.

Function
REQ-016 Transfer in on in_valid&&in_ready&&!flush; transfer out on out_valid&&out_ready.
REQ-017 Latency: accepted instruction appears at head earliest the next cycle (registered decode, no combinational in->out path).
REQ-018 Buffer: FIFO of DEPTH entries, strict order; in_ready = (count < DEPTH), from registered count only (no dependence on out_ready).
REQ-019 Simultaneous push and pop: count unchanged, order preserved; push into a full buffer cannot occur.
REQ-020 Empty: out_valid=0; imm_out, imm_type, instr_out, pc_out hold 0.
REQ-021 Flush: count, read and write pointers cleared next cycle; input presented in the flush cycle dropped; out_ready ignored in flush cycle.
REQ-022 Pointers wrap modulo DEPTH.
REQ-023 Decode by opcode instruction[6:0]; all sign extension to XLEN from instruction[31].
REQ-024 OP-IMM 0010011: funct3 001/101 -> SHAMT, zero-extended instruction[24:20] (XLEN=32) or [25:20] (XLEN=64); else I, sext instruction[31:20].
REQ-025 LOAD 0000011, JALR 1100111 -> I, sext instruction[31:20].
REQ-026 STORE 0100011 -> S, sext {[31:25],[11:7]}.
REQ-027 BRANCH 1100011 -> B, sext {[31],[7],[30:25],[11:8],1'b0}.
REQ-028 LUI 0110111, AUIPC 0010111 -> U, sext {[31:12],12'b0}.
REQ-029 JAL 1101111 -> J, sext {[31],[19:12],[20],[30:21],1'b0}.
REQ-030 Any other opcode -> NONE, imm 0; entry still buffered and delivered.

Reset
REQ-031 rst overrides flush and all transfers: count=0, pointers=0, out_valid=0, all data outputs 0, in_ready=1 on the cycle after rst asserts.
REQ-032 Reset mid-operation discards all buffered entries; no entry is delivered after rst.

Configuration
REQ-033 Macro IMMGEN_CSR_EN defined: SYSTEM 1110011 with funct3[2]=1 -> Z, zero-extended instruction[19:15]; with funct3[2]=0, funct3!=000 -> I, sext instruction[31:20]; funct3=000 -> NONE.
REQ-034 IMMGEN_CSR_EN undefined: opcode 1110011 -> NONE, imm 0.

Structure
REQ-035 Package imm_gen_pkg holds imm_type_t (NONE, I, S, B, U, J, SHAMT, Z) and opcode constants.
REQ-036 Combinational decoder as sub-module imm_decode (instruction in, imm and type out); imm_gen_stage holds FIFO and handshake.

Verification
REQ-037 0xFFF00093 (addi x1,x0,-1), out_ready=1 -> next cycle out_valid=1, imm_out=0xFFFFFFFF, imm_type=I.
REQ-038 0xFE112E23 (sw) -> 0xFFFFFFFC, S; 0xFE000CE3 (beq -8) -> 0xFFFFFFF8, B; 0x123450B7 (lui) -> 0x12345000, U.
REQ-039 out_ready=0, three back-to-back offers, DEPTH=2 -> first two accepted, in_ready=0 from the cycle after the second; release -> delivered in order, third then accepted.
REQ-040 Buffer full, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, offered word never delivered.
REQ-041 0x34011073 (csrrw): IMMGEN_CSR_EN -> imm 0x340, I; 0x3402D073 (csrrwi) -> imm 5, Z; without macro both -> 0, NONE.
REQ-042 rst asserted with two entries buffered -> next cycle out_valid=0, outputs 0, in_ready=1.
